// File: rtl/board_status_scanner_pkg.sv
// ============================================================================
// Module   : board_pkg
// Purpose  : Shared types and defaults for the board status scanner: cell
//            encoding, scanner state encoding, default board geometry and a
//            small width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package board_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10,
    INV   = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_REPORT = 2'b10
  } scan_state_t;

  localparam int c_def_rows    = 6;
  localparam int c_def_cols    = 7;
  localparam int c_def_win_len = 4;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_status_scanner_if.sv
// ============================================================================
// Module   : board_status_scanner_if
// Purpose  : Request/result bundle between the game-control FSM (master) and
//            the board status scanner (slave).
// Signals  : start      - scan request (master -> slave)
//            panel      - live board cells, row 0 on top (master -> slave)
//            busy, done - scanner status / one-cycle result strobe
//            winner, draw, full_panel, col_full - latched scan results
//            illegal    - board sanity flag, present only with BOARD_CHECK_EN
// Macro    : BOARD_CHECK_EN adds the illegal signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface board_status_scanner_if #(
  parameter int ROWS = board_pkg::c_def_rows,
  parameter int COLS = board_pkg::c_def_cols
) ();

  logic                           start;
  logic [0:ROWS-1][0:COLS-1][1:0] panel;
  logic                           busy;
  logic                           done;
  logic [1:0]                     winner;
  logic                           draw;
  logic                           full_panel;
  logic [COLS-1:0]                col_full;
`ifdef BOARD_CHECK_EN
  logic                           illegal;

  modport master (
    output start, panel,
    input  busy, done, winner, draw, full_panel, col_full, illegal
  );

  modport slave (
    input  start, panel,
    output busy, done, winner, draw, full_panel, col_full, illegal
  );
`else
  modport master (
    output start, panel,
    input  busy, done, winner, draw, full_panel, col_full
  );

  modport slave (
    input  start, panel,
    output busy, done, winner, draw, full_panel, col_full
  );
`endif

endinterface

`default_nettype wire

// File: rtl/board_status_scanner_line_checker.sv
// ============================================================================
// Module   : line_checker
// Purpose  : Combinational 4-direction win evaluator for one anchor cell.
//            Checks right, down, down-right and down-left runs of WIN_LEN
//            cells starting at (r, c).
// Ports    : snapshot   - frozen board, row 0 on top
//            r, c       - anchor row / column
//            hit        - some direction forms a winning run
//            hit_colour - colour of that run (00 when no hit)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_checker
  import board_pkg::*;
#(
  parameter int ROWS    = c_def_rows,
  parameter int COLS    = c_def_cols,
  parameter int WIN_LEN = c_def_win_len,
  parameter int ROW_W   = clog2_min1(ROWS),
  parameter int COL_W   = clog2_min1(COLS)
) (
  input  logic [0:ROWS-1][0:COLS-1][1:0] snapshot,
  input  logic [ROW_W-1:0]               r,
  input  logic [COL_W-1:0]               c,
  output logic                           hit,
  output logic [1:0]                     hit_colour
);

  // Cell lookup by integer coordinates; coordinates outside the board read
  // as empty, although callers never rely on that.
  function automatic logic [1:0] cell_at(
    input logic [0:ROWS-1][0:COLS-1][1:0] snap,
    input int rr,
    input int cc
  );
    logic [1:0] v;
    v = 2'b00;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if ((i == rr) && (j == cc)) v = snap[i][j];
      end
    end
    return v;
  endfunction

  // Colour of the run from (r0,c0) along (dr,dc), or 00 if it is not a win.
  function automatic logic [1:0] dir_colour(
    input logic [0:ROWS-1][0:COLS-1][1:0] snap,
    input int r0,
    input int c0,
    input int dr,
    input int dc
  );
    logic [1:0] first;
    logic       ok;
    int         rr;
    int         cc;
    first = cell_at(snap, r0, c0);
    ok    = (first == P1) || (first == P2);
    for (int k = 0; k < WIN_LEN; k++) begin
      rr = r0 + k * dr;
      cc = c0 + k * dc;
      if ((rr < 0) || (rr >= ROWS) || (cc < 0) || (cc >= COLS)) ok = 1'b0;
      else if (cell_at(snap, rr, cc) != first)                  ok = 1'b0;
    end
    return ok ? first : 2'b00;
  endfunction

  logic [1:0] w_right;
  logic [1:0] w_down;
  logic [1:0] w_down_right;
  logic [1:0] w_down_left;

  always_comb begin
    w_right      = dir_colour(snapshot, int'(r), int'(c), 0,  1);
    w_down       = dir_colour(snapshot, int'(r), int'(c), 1,  0);
    w_down_right = dir_colour(snapshot, int'(r), int'(c), 1,  1);
    w_down_left  = dir_colour(snapshot, int'(r), int'(c), 1, -1);
    // Every run begins at the anchor, so all hitting directions share the
    // anchor's colour and OR-ing them is exact.
    hit_colour   = w_right | w_down | w_down_right | w_down_left;
    hit          = |hit_colour;
  end

endmodule

`default_nettype wire

// File: rtl/board_status_scanner.sv
// ============================================================================
// Module   : board_status_scanner
// Purpose  : Sequential win/draw scanner. On start the board is snapshotted,
//            then one anchor per cycle is evaluated in row-major order until
//            the first win or the last anchor; results are latched and
//            reported with a one-cycle done pulse.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - board_status_scanner_if.slave (start/panel in, status and
//                   results out)
// Macro    : BOARD_CHECK_EN enables the illegal-board flag, which masks
//            winner and draw when set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_status_scanner
  import board_pkg::*;
#(
  parameter int ROWS    = c_def_rows,
  parameter int COLS    = c_def_cols,
  parameter int WIN_LEN = c_def_win_len
) (
  input  logic                  clk,
  input  logic                  rst,
  board_status_scanner_if.slave bus
);

  localparam int c_idx_w = clog2_min1(ROWS * COLS);
  localparam int c_row_w = clog2_min1(ROWS);
  localparam int c_col_w = clog2_min1(COLS);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(ROWS * COLS - 1);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(COLS - 1);

  scan_state_t                    r_state;
  scan_state_t                    w_next_state;
  logic [0:ROWS-1][0:COLS-1][1:0] r_snap;
  logic [c_idx_w-1:0]             r_idx;
  logic [c_row_w-1:0]             r_row;
  logic [c_col_w-1:0]             r_col;
  logic [1:0]                     r_winner;
  logic                           r_draw;
  logic                           r_full_panel;
  logic [COLS-1:0]                r_col_full;

  logic                           w_capture;
  logic                           w_advance;
  logic                           w_latch;
  logic                           w_hit;
  logic [1:0]                     w_hit_colour;
  logic [COLS-1:0]                w_col_full;
  logic                           w_full;
  logic [1:0]                     w_winner;
  logic                           w_draw;

  line_checker #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN),
    .ROW_W   (c_row_w),
    .COL_W   (c_col_w)
  ) u_line_checker (
    .snapshot   (r_snap),
    .r          (r_row),
    .c          (r_col),
    .hit        (w_hit),
    .hit_colour (w_hit_colour)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_capture    = 1'b1;
          w_next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_hit || (r_idx == c_last_idx)) begin
          w_latch      = 1'b1;
          w_next_state = ST_REPORT;
        end else begin
          w_advance    = 1'b1;
        end
      end
      ST_REPORT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_REPORT);

  // ------------------------------------------------- result computation
  for (genvar gc = 0; gc < COLS; gc++) begin : g_col_full
    assign w_col_full[gc] = (r_snap[0][gc] != EMPTY);
  end

  assign w_full = &w_col_full;

`ifdef BOARD_CHECK_EN
  logic r_illegal;
  logic w_illegal;

  // Invalid cell codes anywhere, or a piece resting on an empty cell.
  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (r_snap[i][j] == INV) w_illegal = 1'b1;
      end
    end
    for (int i = 0; i < ROWS - 1; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if ((r_snap[i][j] != EMPTY) && (r_snap[i+1][j] == EMPTY)) w_illegal = 1'b1;
      end
    end
  end

  assign w_winner    = (w_illegal || !w_hit) ? 2'b00 : w_hit_colour;
  assign w_draw      = !w_illegal && w_full && (w_winner == 2'b00);
  assign bus.illegal = r_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_illegal <= 1'b0;
    else if (w_latch) r_illegal <= w_illegal;
  end
`else
  assign w_winner = w_hit ? w_hit_colour : 2'b00;
  assign w_draw   = w_full && (w_winner == 2'b00);
`endif

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap       <= '0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_winner     <= 2'b00;
      r_draw       <= 1'b0;
      r_full_panel <= 1'b0;
      r_col_full   <= '0;
    end else begin
      if (w_capture) begin
        r_snap <= bus.panel;
        r_idx  <= '0;
        r_row  <= '0;
        r_col  <= '0;
      end else if (w_advance) begin
        // Row/column are tracked alongside the flat index to avoid a divider.
        r_idx <= r_idx + c_idx_w'(1);
        if (r_col == c_last_col) begin
          r_col <= '0;
          r_row <= r_row + c_row_w'(1);
        end else begin
          r_col <= r_col + c_col_w'(1);
        end
      end
      // Results persist until the next latch, even across a new start.
      if (w_latch) begin
        r_winner     <= w_winner;
        r_draw       <= w_draw;
        r_full_panel <= w_full;
        r_col_full   <= w_col_full;
      end
    end
  end

  assign bus.winner     = r_winner;
  assign bus.draw       = r_draw;
  assign bus.full_panel = r_full_panel;
  assign bus.col_full   = r_col_full;

endmodule

`default_nettype wire
